npc_ctrl: RTL
=============

# npc_ctrl

Next-PC controller for the 5-stage RV32 pipeline. Each cycle it decides the PC register's next value and write enable. It arbitrates between sequential fetch, ID-stage jumps, EX-stage taken branches, load-use stalls, halt, and an optional trap, and it drives the matching IF/ID and ID/EX flush/hold controls. It also owns the post-reset boot wait and the halt state, which keeps the PC register itself a plain loadable register.

## Interface
- RESET_PC, 32'h0000_0000, value presented on npc during BOOT
- BOOT_WAIT, 1, cycles pc_we held low after reset release (1..15)
- TRAP_VEC, 32'h0000_0100, trap target (used only with NPC_CTRL_TRAP_EN)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc  in  32  current PC register value
- br_taken  in  1  EX-stage branch resolved taken
- br_target  in  32  EX-stage branch target
- jmp_valid  in  1  ID-stage jal/jalr decoded
- jmp_target  in  32  ID-stage jump target
- stall_req  in  1  load-use hazard from hazard unit
- halt_req  in  1  ebreak reached WB
- trap_req  in  1  trap request (ignored without macro)
- npc  out  32  next PC value
- pc_we  out  1  PC register load enable
- if_id_flush  out  1  clear IF/ID to NOP
- if_id_hold  out  1  hold IF/ID contents
- id_ex_flush  out  1  insert bubble into ID/EX
- halted  out  1  controller in HALT
- redirect_cnt  out  16  count of taken redirects
- mepc  out  32  PC captured at trap (0 without macro)

## Operation
- States: BOOT, RUN, HALT (registered).
- BOOT: npc=RESET_PC, pc_we=0, all flush/hold=0. A 4-bit wait counter loads BOOT_WAIT on reset and decrements each cycle. Transition to RUN when the counter equals 1. All other inputs are ignored.
- RUN: requests are evaluated combinationally, with fixed priority trap > halt > br_taken > jmp_valid > stall_req > sequential.
  - trap: npc=TRAP_VEC, pc_we=1, if_id_flush=1, id_ex_flush=1, mepc<=pc, redirect_cnt+1.
  - halt: pc_we=0, if_id_flush=1, id_ex_flush=1. Next state HALT.
  - br_taken: npc=br_target, pc_we=1, if_id_flush=1, id_ex_flush=1, redirect_cnt+1. Any concurrent stall or jump is dropped, because the older instruction wins.
  - jmp_valid (no br_taken, no stall_req): npc=jmp_target, pc_we=1, if_id_flush=1, redirect_cnt+1.
  - stall_req (no br_taken): pc_we=0, if_id_hold=1, id_ex_flush=1. A concurrent jmp_valid is ignored, and the jump re-decodes next cycle.
  - sequential: npc=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), pc_we=1.
- Targets: npc[1:0] is forced to 2'b00 for every redirect source.
- HALT: pc_we=0, halted=1, flush/hold=0. The state is left only by reset.
- redirect_cnt: wraps from 16'hFFFF to 0.
- Reset values (async): state=BOOT, wait counter=BOOT_WAIT, redirect_cnt=0, mepc=0. The combinational outputs in BOOT are npc=RESET_PC, pc_we=0, flushes/hold=0, halted=0.

## Timing
- npc, pc_we, and the flush/hold outputs are combinational from state and inputs. They must settle in the same cycle the request is asserted.
- state, wait counter, redirect_cnt, and mepc update on the rising clk edge.
- Redirect latency is zero controller cycles: the PC register loads the target on the edge ending the request cycle.
- With BOOT_WAIT=N, the first pc_we=1 occurs in cycle N after rst_n deasserts (cycles counted from 0).
- When rst_n asserts mid-operation, all registers return to reset values immediately. Any in-flight redirect is discarded.

## Configuration
- NPC_CTRL_TRAP_EN defined: trap_req participates at the highest priority, TRAP_VEC is used, and the mepc register is implemented.
- NPC_CTRL_TRAP_EN undefined: trap_req is ignored, mepc is tied to 32'h0, and no mepc register is synthesised. Priority starts at halt.

## Test plan
- Reset with BOOT_WAIT=3, pc=0 → pc_we=0 in cycles 0–2, npc=0; cycle 3 pc_we=1, npc=4.
- RUN, pc=32'h40, stall_req=1 and jmp_valid=1 (jmp_target=32'h80) → pc_we=0, if_id_hold=1, id_ex_flush=1, redirect_cnt unchanged; next cycle stall_req=0, jmp_valid=1 → npc=32'h80, if_id_flush=1, redirect_cnt=1.
- br_taken=1 (br_target=32'h203) with jmp_valid=1 and stall_req=1 → npc=32'h200, pc_we=1, both flushes=1, redirect_cnt+1.
- pc=32'hFFFF_FFFC, no requests → npc=32'h0000_0000, pc_we=1.
- halt_req=1 together with br_taken=1 → pc_we=0, both flushes=1; from the next cycle halted=1 and pc_we=0 stays until rst_n pulses; after reset the controller is in BOOT.
- With NPC_CTRL_TRAP_EN, pc=32'h1C, trap_req=1 with br_taken=1 → npc=32'h100, mepc=32'h1C next cycle. Without the macro, the same stimulus gives npc=br_target and mepc=0.

Source files
------------

// File: rtl/npc_if.sv
// Request/response bundle between the pipeline and the next-PC controller.
// master: pipeline side (drives requests); slave: npc_ctrl.
interface npc_if;
  logic [31:0] pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        stall_req;
  logic        halt_req;
  logic        trap_req;
  logic [31:0] npc;
  logic        pc_we;
  logic        if_id_flush;
  logic        if_id_hold;
  logic        id_ex_flush;
  logic        halted;
  logic [15:0] redirect_cnt;
  logic [31:0] mepc;

  modport master (
    output pc, br_taken, br_target, jmp_valid, jmp_target, stall_req, halt_req, trap_req,
    input  npc, pc_we, if_id_flush, if_id_hold, id_ex_flush, halted, redirect_cnt, mepc
  );

  modport slave (
    input  pc, br_taken, br_target, jmp_valid, jmp_target, stall_req, halt_req, trap_req,
    output npc, pc_we, if_id_flush, if_id_hold, id_ex_flush, halted, redirect_cnt, mepc
  );
endinterface

// File: rtl/npc_ctrl.sv
// Next-PC controller: boot wait, redirect arbitration, halt and pipeline flush/hold.
// Optional trap support is enabled with `define NPC_CTRL_TRAP_EN.
module npc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [3:0]  BOOT_WAIT = 4'd1,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic  clk,
  input  logic  rst_n,
  npc_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [15:0] redirect_cnt_q;
  logic        redirect;
  logic        trap;
  logic        trap_take;

`ifdef NPC_CTRL_TRAP_EN
  assign trap = bus.trap_req;
`else
  logic unused_trap;
  assign trap        = 1'b0;
  assign unused_trap = bus.trap_req;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt       = state;
    bus.npc         = bus.pc + 32'd4;
    bus.pc_we       = 1'b0;
    bus.if_id_flush = 1'b0;
    bus.if_id_hold  = 1'b0;
    bus.id_ex_flush = 1'b0;
    redirect        = 1'b0;
    trap_take       = 1'b0;

    unique case (state)
      BOOT: begin
        bus.npc = RESET_PC;
        if (wait_cnt == 4'd1) state_nxt = RUN;
      end
      RUN: begin
        if (trap) begin
          bus.npc         = TRAP_VEC & ALIGN_MASK;
          bus.pc_we       = 1'b1;
          bus.if_id_flush = 1'b1;
          bus.id_ex_flush = 1'b1;
          redirect        = 1'b1;
          trap_take       = 1'b1;
        end else if (bus.halt_req) begin
          bus.if_id_flush = 1'b1;
          bus.id_ex_flush = 1'b1;
          state_nxt       = HALT;
        end else if (bus.br_taken) begin
          // The branch is older than any instruction stalling or jumping behind it.
          bus.npc         = bus.br_target & ALIGN_MASK;
          bus.pc_we       = 1'b1;
          bus.if_id_flush = 1'b1;
          bus.id_ex_flush = 1'b1;
          redirect        = 1'b1;
        end else if (bus.stall_req) begin
          // A jump held in ID re-decodes once the stall clears.
          bus.if_id_hold  = 1'b1;
          bus.id_ex_flush = 1'b1;
        end else if (bus.jmp_valid) begin
          bus.npc         = bus.jmp_target & ALIGN_MASK;
          bus.pc_we       = 1'b1;
          bus.if_id_flush = 1'b1;
          redirect        = 1'b1;
        end else begin
          bus.pc_we = 1'b1;
        end
      end
      HALT: begin
        bus.npc = bus.pc;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  assign bus.halted       = (state == HALT);
  assign bus.redirect_cnt = redirect_cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BOOT;
      wait_cnt       <= BOOT_WAIT;
      redirect_cnt_q <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == BOOT) wait_cnt <= wait_cnt - 4'd1;
      if (redirect) redirect_cnt_q <= redirect_cnt_q + 16'd1;
    end
  end

`ifdef NPC_CTRL_TRAP_EN
  logic [31:0] mepc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q <= 32'd0;
    end else if (trap_take) begin
      mepc_q <= bus.pc;
    end
  end

  assign bus.mepc = mepc_q;
`else
  logic unused_trap_take;
  assign unused_trap_take = trap_take;
  assign bus.mepc         = 32'd0;
`endif

endmodule
